// File: rtl/encoder_4to2_buf_if.sv
// Handshake and data bundle for encoder_4to2_buf.
// ERR is present only when ENC4_MULTIHOT_ERR_EN is defined.
interface encoder_4to2_buf_if;
  logic EN;
  logic D3, D2, D1, D0;
  logic RDY;
  logic A1, A0;
  logic V;
  logic VLD;
  logic ACK;
`ifdef ENC4_MULTIHOT_ERR_EN
  logic ERR;

  modport master (
    output EN, D3, D2, D1, D0, ACK,
    input  RDY, A1, A0, V, VLD, ERR
  );
  modport slave (
    input  EN, D3, D2, D1, D0, ACK,
    output RDY, A1, A0, V, VLD, ERR
  );
`else
  modport master (
    output EN, D3, D2, D1, D0, ACK,
    input  RDY, A1, A0, V, VLD
  );
  modport slave (
    input  EN, D3, D2, D1, D0, ACK,
    output RDY, A1, A0, V, VLD
  );
`endif
endinterface

// File: rtl/encoder_4to2_buf.sv
// Priority 4-to-2 encoder feeding a 2-entry FIFO; entry0 drives the outputs.
// Optional multi-hot ERR flag per word under ENC4_MULTIHOT_ERR_EN.
module encoder_4to2_buf (
  input  logic              CLK,
  input  logic              RST,
  encoder_4to2_buf_if.slave bus
);
`ifdef ENC4_MULTIHOT_ERR_EN
  localparam int W = 4;
`else
  localparam int W = 3;
`endif

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   entry0_q, entry0_d;
  logic [W-1:0]   entry1_q, entry1_d;
  logic [W-1:0]   word_in;
  logic [3:0]     d_vec;
  logic [1:0]     idx;
  logic           push, pop;

  assign d_vec = {bus.D3, bus.D2, bus.D1, bus.D0};

  always_comb begin
    idx = 2'd0;
    if (d_vec[3])      idx = 2'd3;
    else if (d_vec[2]) idx = 2'd2;
    else if (d_vec[1]) idx = 2'd1;
  end

  // Word layout: [1:0] index, [2] valid-line flag, [3] multi-hot flag when present.
`ifdef ENC4_MULTIHOT_ERR_EN
  assign word_in = {((d_vec & (d_vec - 4'd1)) != 4'd0), (d_vec != 4'd0), idx};
`else
  assign word_in = {(d_vec != 4'd0), idx};
`endif

  assign push = bus.EN  && (state_q != TWO);
  assign pop  = bus.ACK && (state_q != EMPTY);

  always_comb begin
    state_d  = state_q;
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d  = ONE;
          entry0_d = word_in;
        end
      end
      ONE: begin
        if (push && pop) begin
          entry0_d = word_in;
        end else if (push) begin
          state_d  = TWO;
          entry1_d = word_in;
        end else if (pop) begin
          state_d  = EMPTY;
          entry0_d = '0;
        end
      end
      TWO: begin
        if (pop) begin
          state_d  = ONE;
          entry0_d = entry1_q;
          entry1_d = '0;
        end
      end
      default: begin
        state_d  = EMPTY;
        entry0_d = '0;
        entry1_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= EMPTY;
      entry0_q <= '0;
      entry1_q <= '0;
    end else begin
      state_q  <= state_d;
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
    end
  end

  assign bus.RDY = (state_q != TWO);
  assign bus.VLD = (state_q != EMPTY);
  assign bus.A1  = entry0_q[1];
  assign bus.A0  = entry0_q[0];
  assign bus.V   = entry0_q[2];
`ifdef ENC4_MULTIHOT_ERR_EN
  assign bus.ERR = entry0_q[3];
`endif
endmodule

// File: tb/tb_encoder_4to2_buf.sv
// Directed plus random bench for encoder_4to2_buf against a queue-based model.
module tb_encoder_4to2_buf;
  logic CLK;
  logic RST;
  int   vectors;
  int   miscompares;
  logic [3:0] model_q[$];

  encoder_4to2_buf_if bus ();

  encoder_4to2_buf dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model word: {err, v, index}; index = position of highest set line.
  function automatic logic [3:0] ref_word(input logic [3:0] d);
    int hi;
    int n;
    hi = 0;
    n  = 0;
    for (int i = 0; i < 4; i++) begin
      if (d[i]) begin
        hi = i;
        n  = n + 1;
      end
    end
    return {(n >= 2), (n > 0), 2'(hi)};
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    logic [3:0] head;
    head = (model_q.size() > 0) ? model_q[0] : 4'h0;
    chk({tag, ".vld"}, {3'b0, bus.VLD}, {3'b0, model_q.size() > 0});
    chk({tag, ".rdy"}, {3'b0, bus.RDY}, {3'b0, model_q.size() < 2});
    chk({tag, ".a"},   {2'b0, bus.A1, bus.A0}, {2'b0, head[1:0]});
    chk({tag, ".v"},   {3'b0, bus.V}, {3'b0, head[2]});
`ifdef ENC4_MULTIHOT_ERR_EN
    chk({tag, ".err"}, {3'b0, bus.ERR}, {3'b0, head[3]});
`endif
  endtask

  task automatic step(input string tag, input logic en, input logic [3:0] d, input logic ack);
    int pre_size;
    @(negedge CLK);
    bus.EN  = en;
    {bus.D3, bus.D2, bus.D1, bus.D0} = d;
    bus.ACK = ack;
    pre_size = model_q.size();
    @(posedge CLK);
    if (ack && pre_size > 0) void'(model_q.pop_front());
    if (en && pre_size < 2) model_q.push_back(ref_word(d));
    #1;
    chk_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge CLK);
    bus.EN  = 1'b0;
    bus.ACK = 1'b0;
    RST     = 1'b1;
    #1;
    model_q.delete();
    chk_all(tag);
    #2;
    RST = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    RST     = 1'b1;
    bus.EN  = 1'b0;
    bus.ACK = 1'b0;
    {bus.D3, bus.D2, bus.D1, bus.D0} = 4'b0000;
    #1;
    chk_all("reset0");
    #2;
    RST = 1'b0;

    // Streaming one-hot words with ACK held high
    step("stream0", 1'b1, 4'b0001, 1'b1);
    step("stream1", 1'b1, 4'b0010, 1'b1);
    step("stream2", 1'b1, 4'b0100, 1'b1);
    step("stream3", 1'b1, 4'b1000, 1'b1);
    chk("stream3.a_const", {2'b0, bus.A1, bus.A0}, 4'h3);
    step("stream_drain", 1'b0, 4'b0000, 1'b1);

    // Fill, overflow attempt, drain
    step("fill0", 1'b1, 4'b1000, 1'b0);
    step("fill1", 1'b1, 4'b0010, 1'b0);
    chk("fill1.rdy_const", {3'b0, bus.RDY}, 4'h0);
    step("drop", 1'b1, 4'b0001, 1'b0);
    chk("drop.a_const", {2'b0, bus.A1, bus.A0}, 4'h3);
    step("pop0", 1'b0, 4'b0000, 1'b1);
    chk("pop0.a_const", {2'b0, bus.A1, bus.A0}, 4'h1);
    step("pop1", 1'b0, 4'b0000, 1'b1);
    chk("pop1.vld_const", {3'b0, bus.VLD}, 4'h0);

    // All-zero word
    step("zero", 1'b1, 4'b0000, 1'b0);
    chk("zero.vld_const", {3'b0, bus.VLD}, 4'h1);
    step("zero_pop", 1'b0, 4'b0000, 1'b1);

    // Simultaneous push and pop in ONE
    step("one_fill", 1'b1, 4'b0001, 1'b0);
    step("one_swap", 1'b1, 4'b0100, 1'b1);
    chk("one_swap.a_const", {2'b0, bus.A1, bus.A0}, 4'h2);
    step("one_pop", 1'b0, 4'b0000, 1'b1);

    // Multi-hot words
    step("mh0", 1'b1, 4'b1010, 1'b0);
    step("mh1", 1'b1, 4'b0010, 1'b1);
    step("mh2", 1'b0, 4'b0000, 1'b1);
    step("mh3", 1'b1, 4'b1111, 1'b0);
    step("mh4", 1'b0, 4'b0000, 1'b1);

    // Async reset with two entries held
    step("pre_rst0", 1'b1, 4'b1000, 1'b0);
    step("pre_rst1", 1'b1, 4'b0001, 1'b0);
    do_reset("mid_rst");
    step("post_rst", 1'b1, 4'b0100, 1'b0);
    chk("post_rst.a_const", {2'b0, bus.A1, bus.A0}, 4'h2);
    step("post_rst_pop", 1'b0, 4'b0000, 1'b1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step("rand", 1'($urandom_range(0, 99) < 60), 4'($urandom), 1'($urandom_range(0, 99) < 50));
      if ($urandom_range(0, 99) == 0) do_reset("rand_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
